// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_pkg;

  localparam int unsigned MEM_AW = 16;
  localparam int unsigned MEM_DW = 16;

  localparam logic MODE_BYTE = 1'b0;
  localparam logic MODE_WORD = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    CAPTURE,
    RESP
  } state_t;

  typedef struct packed {
    logic              we;
    logic              word;
    logic              sign_ext;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_load_align.sv
// Right-aligns and extends Data_memory read data; byte reads arrive in the top byte lane.
module mem_load_align #(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] rdata,
  input  logic          word,
  input  logic          sign_ext,
  output logic [DW-1:0] aligned
);

  logic [7:0] hi_byte;

  always_comb begin
    hi_byte = rdata[DW-1 -: 8];
    if (word) begin
      aligned = rdata;
    end else begin
      aligned = {{(DW-8){sign_ext & hi_byte[7]}}, hi_byte};
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of Data_memory: one-edge strobe, settle wait, aligned response.
// Optional performance counters are built when MEM_ACCESS_CTRL_PERF_EN is defined.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned AW         = MEM_AW,
  parameter int unsigned DW         = MEM_DW,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic          req_word,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_fault,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_mode,
  input  logic [DW-1:0] mem_rdata
`ifdef MEM_ACCESS_CTRL_PERF_EN
  ,
  output logic [15:0]   perf_loads,
  output logic [15:0]   perf_stores,
  output logic [15:0]   perf_faults
`endif
);

  localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYC - 1);

  state_t        state;
  req_t          in_req;
  logic          ctl_we;
  logic          ctl_word;
  logic          ctl_sign;
  logic [1:0]    settle_cnt;
  logic          in_fault;
  logic [DW-1:0] load_val;

  always_comb begin
    in_req          = '0;
    in_req.we       = req_we;
    in_req.word     = req_word;
    in_req.sign_ext = req_signed;
    in_req.addr     = req_addr;
    in_req.wdata    = req_wdata;
  end

  assign in_fault = (in_req.addr == '0) || (in_req.word && in_req.addr[0]);

  mem_load_align #(.DW(DW)) u_load_align (
    .rdata    (mem_rdata),
    .word     (ctl_word),
    .sign_ext (ctl_sign),
    .aligned  (load_val)
  );

  // Memory-side outputs are loaded on the accept edge so the strobe is high
  // for the whole ISSUE cycle; resp_valid rises one edge after entering RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ctl_we      <= 1'b0;
      ctl_word    <= 1'b0;
      ctl_sign    <= 1'b0;
      settle_cnt  <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_fault  <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_mode    <= MODE_BYTE;
`ifdef MEM_ACCESS_CTRL_PERF_EN
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_faults <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            ctl_we    <= in_req.we;
            ctl_word  <= in_req.word;
            ctl_sign  <= in_req.sign_ext;
            req_ready <= 1'b0;
            if (in_fault) begin
              resp_fault <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else begin
              resp_fault <= 1'b0;
              mem_read   <= !in_req.we;
              mem_write  <= in_req.we;
              mem_addr   <= in_req.addr;
              mem_mode   <= in_req.word ? MODE_WORD : MODE_BYTE;
              mem_wdata  <= in_req.word ? in_req.wdata : {in_req.wdata[7:0], 8'h00};
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 2'd1;
          end
        end
        CAPTURE: begin
          resp_rdata <= ctl_we ? '0 : load_val;
          state      <= RESP;
        end
        RESP: begin
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
`ifdef MEM_ACCESS_CTRL_PERF_EN
            if (resp_fault) begin
              perf_faults <= perf_faults + 16'd1;
            end else if (ctl_we) begin
              perf_stores <= perf_stores + 16'd1;
            end else begin
              perf_loads  <= perf_loads + 16'd1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed scoreboard bench for mem_access_ctrl with a behavioural Data_memory model.
module tb_mem_access_ctrl;

  localparam int unsigned SETTLE = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_word;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_mode;
  logic [15:0] mem_rdata;
`ifdef MEM_ACCESS_CTRL_PERF_EN
  logic [15:0] perf_loads;
  logic [15:0] perf_stores;
  logic [15:0] perf_faults;
`endif

  mem_access_ctrl #(.AW(16), .DW(16), .SETTLE_CYC(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_word   (req_word),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_mode   (mem_mode),
    .mem_rdata  (mem_rdata)
`ifdef MEM_ACCESS_CTRL_PERF_EN
    ,
    .perf_loads  (perf_loads),
    .perf_stores (perf_stores),
    .perf_faults (perf_faults)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rdata;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem_bytes [256];
  logic [7:0]  ref_bytes [256];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned rd_cnt = 0;
  int unsigned wr_cnt = 0;
  int unsigned both_cnt = 0;
  int unsigned exp_loads = 0;
  int unsigned exp_stores = 0;
  int unsigned exp_faults = 0;
  logic [15:0] wr_addr_seen;
  logic [15:0] wr_data_seen;
  logic        wr_mode_seen;
  logic [15:0] rd_addr_seen;
  logic        rd_mode_seen;

  // Data_memory model: byte reads come back in the top lane, words big-endian.
  always @(posedge clk) begin
    if (mem_write) begin
      mem_bytes[mem_addr[7:0]] <= mem_wdata[15:8];
      if (mem_mode) mem_bytes[mem_addr[7:0] + 8'd1] <= mem_wdata[7:0];
    end
    if (mem_read) begin
      mem_rdata <= mem_mode ? {mem_bytes[mem_addr[7:0]], mem_bytes[mem_addr[7:0] + 8'd1]}
                            : {mem_bytes[mem_addr[7:0]], 8'h00};
    end
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) both_cnt++;
    if (mem_read) begin
      rd_cnt++;
      rd_addr_seen = mem_addr;
      rd_mode_seen = mem_mode;
    end
    if (mem_write) begin
      wr_cnt++;
      wr_addr_seen = mem_addr;
      wr_data_seen = mem_wdata;
      wr_mode_seen = mem_mode;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge one cycle after the response handshake.
  task automatic run_req(input string tag, input logic we, input logic word, input logic sgn,
                         input logic [15:0] addr, input logic [15:0] wdata, input int unsigned hold);
    exp_t        e;
    exp_t        got;
    logic        flt;
    logic [7:0]  a;
    int unsigned k;
    int unsigned lat;
    int unsigned rd0;
    int unsigned wr0;
    logic [15:0] rd_s;
    logic        ft_s;
    flt     = (addr == 16'h0000) || (word && addr[0]);
    a       = addr[7:0];
    e.fault = flt;
    e.rdata = 16'h0000;
    if (!flt) begin
      if (we) begin
        ref_bytes[a] = word ? wdata[15:8] : wdata[7:0];
        if (word) ref_bytes[a + 8'd1] = wdata[7:0];
      end else if (word) begin
        e.rdata = {ref_bytes[a], ref_bytes[a + 8'd1]};
      end else begin
        e.rdata = {{8{sgn & ref_bytes[a][7]}}, ref_bytes[a]};
      end
    end
    sb.push_back(e);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    req_valid  = 1'b1;
    req_we     = we;
    req_word   = word;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    k = 0;
    while (!req_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_ready_drop"}, 32'(req_ready), 32'd0);
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, flt ? 32'd1 : 32'(3 + SETTLE));
    rd_s = resp_rdata;
    ft_s = resp_fault;
    for (int i = 0; i < int'(hold); i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_hold_rdata"}, 32'(resp_rdata), 32'(rd_s));
      check({tag, "_hold_fault"}, 32'(resp_fault), 32'(ft_s));
      check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    got = sb.pop_front();
    check({tag, "_rdata"}, 32'(resp_rdata), 32'(got.rdata));
    check({tag, "_fault"}, 32'(resp_fault), 32'(got.fault));
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    check({tag, "_nreads"}, rd_cnt - rd0, (!flt && !we) ? 32'd1 : 32'd0);
    check({tag, "_nwrites"}, wr_cnt - wr0, (!flt && we) ? 32'd1 : 32'd0);
    if (!flt && we) begin
      check({tag, "_wdata"}, 32'(wr_data_seen), word ? 32'(wdata) : 32'({wdata[7:0], 8'h00}));
      check({tag, "_waddr"}, 32'(wr_addr_seen), 32'(addr));
      check({tag, "_wmode"}, 32'(wr_mode_seen), 32'(word));
    end
    if (!flt && !we) begin
      check({tag, "_raddr"}, 32'(rd_addr_seen), 32'(addr));
      check({tag, "_rmode"}, 32'(rd_mode_seen), 32'(word));
    end
    if (flt) exp_faults++;
    else if (we) exp_stores++;
    else exp_loads++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_word   = 1'b0;
    req_signed = 1'b0;
    req_addr   = 16'h0000;
    req_wdata  = 16'h0000;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_resp_fault", 32'(resp_fault), 32'd0);
    check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_req("wst_10",  1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 0);
    run_req("wld_10",  1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 0);
    run_req("bst_21",  1'b1, 1'b0, 1'b0, 16'h0021, 16'h0080, 0);
    run_req("bld_s21", 1'b0, 1'b0, 1'b1, 16'h0021, 16'h0000, 0);
    run_req("bld_u21", 1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000, 0);
    run_req("wld_odd", 1'b0, 1'b1, 1'b0, 16'h0013, 16'h0000, 0);
    run_req("bld_0",   1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0);
    run_req("hold_10", 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 5);

    // Abandon a load while it is settling.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_word  = 1'b1;
    req_addr  = 16'h0010;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_resp_fault", 32'(resp_fault), 32'd0);
    check("arst_strobes", 32'({mem_read, mem_write}), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_mem_mode", 32'(mem_mode), 32'd0);
    check("arst_mem_wdata", 32'(mem_wdata), 32'd0);
    exp_loads  = 0;
    exp_stores = 0;
    exp_faults = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_req("post_wld", 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 0);
    run_req("wst_30",   1'b1, 1'b1, 1'b0, 16'h0030, 16'h1234, 0);
    run_req("wst_ffff", 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h5555, 0);
    run_req("bst_ffff", 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h00A5, 0);
    run_req("bld_ffff", 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 0);
    run_req("wld_30",   1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 0);

    check("strobes_overlap", both_cnt, 32'd0);
`ifdef MEM_ACCESS_CTRL_PERF_EN
    check("perf_loads", 32'(perf_loads), exp_loads);
    check("perf_stores", 32'(perf_stores), exp_stores);
    check("perf_faults", 32'(perf_faults), exp_faults);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sits directly upstream of Data_memory, between the EX/MEM pipeline boundary and the memory.
- Accepts one load/store request per transaction over a valid/ready handshake and drives Data_memory's MemRead/MemWrite/Address/WriteData/mode for exactly one clock edge.
- Captures ReadData after the memory's post-edge settling, aligns and extends byte data, and presents a registered response to writeback.
- Rejects accesses the memory cannot service: address 0, and odd-address word access.

Parameters:
- AW, 16, address width (byte address).
- DW, 16, data width.
- SETTLE_CYC, 1, idle cycles after the issue edge before ReadData is sampled; range 1-3.

Ports:
- clk, in, 1, clock; all state updates on posedge.
- rst_n, in, 1, reset, asynchronous, active-low.
- req_valid, in, 1, request present.
- req_ready, out, 1, controller can accept a request.
- req_we, in, 1, 1 = store, 0 = load.
- req_word, in, 1, 1 = 16-bit access, 0 = byte access.
- req_signed, in, 1, byte loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr, in, AW, byte address.
- req_wdata, in, DW, store data; byte stores use [7:0].
- resp_valid, out, 1, response present.
- resp_ready, in, 1, writeback accepts the response.
- resp_rdata, out, DW, load result, right-aligned; 0 for stores and faults.
- resp_fault, out, 1, request rejected; no memory access was made.
- mem_read, out, 1, to MemRead.
- mem_write, out, 1, to MemWrite.
- mem_addr, out, AW, to Address.
- mem_wdata, out, DW, to WriteData.
- mem_mode, out, 1, to mode (0 = byte, 1 = word).
- mem_rdata, in, DW, from ReadData.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. req_ready=1. resp_valid=0, resp_rdata=0, resp_fault=0. mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, mem_mode=0. Reset mid-transaction abandons it; a write already issued on a completed edge stays in memory.
- All outputs are registered. req_ready=1 only in IDLE.
- FSM states: IDLE, ISSUE, SETTLE, CAPTURE, RESP.
- IDLE:
  - On req_valid && req_ready, latch the request.
  - If req_addr==0, or (req_word && req_addr[0]): go to RESP with resp_fault=1 and rdata=0. No mem strobe is asserted.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - mem_read = !we and mem_write = we, for exactly one posedge.
  - mem_addr = addr, mem_mode = word.
  - mem_wdata = word ? wdata : {wdata[7:0], 8'h00}.
  - Next state: SETTLE.
- SETTLE: strobes are 0; mem_addr and mem_mode hold their values. Stay SETTLE_CYC cycles, then go to CAPTURE.
- CAPTURE (1 cycle):
  - Word load: rdata = mem_rdata.
  - Byte load: rdata = {8{signed & mem_rdata[15]}, mem_rdata[15:8]}.
  - Store: rdata = 0.
  - Next state: RESP.
- RESP: resp_valid=1. Hold resp_rdata and resp_fault stable until resp_ready. When resp_valid && resp_ready, go to IDLE.
- Latency, SETTLE_CYC=1, accept at edge 0: ISSUE in cycle 1, SETTLE in cycle 2, CAPTURE in cycle 3, resp_valid rises after edge 4. A fault gives resp_valid after edge 1.
- No back-to-back acceptance: req_ready rises the cycle after the response handshake. Requests are never dropped; the upstream stage holds req_valid.
- Strobes are never asserted together. mem_read and mem_write are never high outside ISSUE.
- Address 0xFFFF byte access is legal. Word access at 0xFFFF faults (odd address).

Optional Feature:
- Macro: MEM_ACCESS_CTRL_PERF_EN.
- With it defined, three additional ports are present:
  - perf_loads, out, 16: count of completed non-fault loads.
  - perf_stores, out, 16: count of completed non-fault stores.
  - perf_faults, out, 16: count of faults.
  - Each counter increments on the response handshake, wraps at 0xFFFF to 0, and resets to 0.
- Without it, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mem_pkg:
  - State enum {IDLE, ISSUE, SETTLE, CAPTURE, RESP}.
  - MODE_BYTE=0, MODE_WORD=1.
  - AW/DW defaults.
  - A request struct (we, word, signed, addr, wdata).
- One natural sub-module: mem_load_align. It is combinational: it takes mem_rdata, word and signed, and returns the right-aligned, extended load value. It is instantiated in CAPTURE.

Test Plan:
- Word store 0xBEEF @0x0010, then word load @0x0010 -> stores: mem_write high for exactly one edge, mem_wdata=0xBEEF, mode=1. Load: resp_rdata=0xBEEF, resp_fault=0, resp_valid after edge 4.
- Byte store 0x0080 @0x0021, then byte load @0x0021 with signed=1 and again with signed=0 -> mem_wdata=0x8000, mode=0; signed load resp_rdata=0xFF80, unsigned load resp_rdata=0x0080.
- Word load @0x0013, and byte load @0x0000 -> resp_fault=1 and resp_rdata=0 one cycle after accept; mem_read/mem_write never asserted.
- Hold resp_ready=0 for 5 cycles on a load response -> resp_valid, resp_rdata and resp_fault stay stable; req_ready stays 0; a pending req_valid is accepted only after the handshake.
- Deassert rst_n during SETTLE of a load -> outputs return to reset values immediately (asynchronous); the next request completes normally.
- With MEM_ACCESS_CTRL_PERF_EN: 3 loads, 2 stores and 1 fault -> perf_loads=3, perf_stores=2, perf_faults=1.
